rv32i_dec_stage: RTL and testbench
==================================

RV32I_DEC_STAGE -- requirements
Module: rv32i_dec_stage

Interface
REQ-001 Parameter: ILL_CHECK, default 1, 1 = unsupported encodings raise ex_ill; 0 = ex_ill tied 0.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 fch_vld  in  1  fetch presents an instruction.
REQ-005 fch_rdy  out  1  stage accepts the instruction this cycle.
REQ-006 fch_ir  in  32  raw instruction word.
REQ-007 fch_pc  in  32  PC of fch_ir.
REQ-008 flush  in  1  discard all held and incoming instructions.
REQ-009 ex_vld  out  1  decoded bundle valid.
REQ-010 ex_rdy  in  1  execute consumes the bundle.
REQ-011 ex_pc  out  32  PC of the bundle.
REQ-012 ex_opcode  out  7  ir[6:0].
REQ-013 ex_fmt  out  3  format code: R, I, S, B, U, J, NONE.
REQ-014 ex_rd, ex_rs1, ex_rs2  out  5 each  register indices (0 when the format has no such field).
REQ-015 ex_funct3  out  3; ex_funct7  out  7 (funct7 is 0 unless fmt = R).
REQ-016 ex_imm  out  32  sign/zero-extended immediate for the format; 0 for R/NONE.
REQ-017 ex_rd_we  out  1  write-back required: fmt in {R,I,U,J} and rd != 0, and not illegal.
REQ-018 ex_ill  out  1  illegal instruction flag.

Function
REQ-019 Fetch-side transfer occurs when fch_vld & fch_rdy; execute-side transfer occurs when ex_vld & ex_rdy.
REQ-020 Decode is combinational on fch_ir; the registered bundle appears on ex_* exactly 1 cycle after the fetch transfer when the output register is empty or being drained.
REQ-021 Storage: one output register (OUT) plus one skid register (SKID); capacity is 2 instructions.
REQ-022 fch_rdy = !skid_vld; it is a registered signal with no combinational path from ex_rdy.
REQ-023 State machine: EMPTY (no valid entries), ONE (OUT valid), FULL (OUT and SKID valid).
REQ-024 EMPTY->ONE on fetch transfer.
REQ-025 ONE->ONE on simultaneous fetch and execute transfers; ONE->EMPTY on execute transfer only; ONE->FULL on fetch transfer with !ex_rdy.
REQ-026 FULL->ONE on execute transfer: SKID moves to OUT; no fetch is accepted in FULL.
REQ-027 While ex_vld & !ex_rdy, all ex_* outputs SHALL hold stable.
REQ-028 Ordering is strictly preserved: no loss, duplication or reordering.
REQ-029 Flush: the next state is EMPTY, and any instruction offered in the flush cycle is dropped; flush takes priority over all transfers.
REQ-030 Opcode-to-format map (ir[6:0]):
- 0110111/0010111 -> U
- 1101111 -> J
- 1100111/0000011/0010011/0001111/1110011 -> I
- 1100011 -> B
- 0100011 -> S
- 0110011 -> R
- all others -> NONE
REQ-031 ex_ill = ILL_CHECK & (fmt == NONE | ir[1:0] != 2'b11); an illegal bundle still flows through the handshake normally.
REQ-032 Immediates follow RV32I bit placement; B and J immediates have bit 0 = 0; U immediate is ir[31:12] followed by 12 zero bits.

Reset
REQ-033 On rst, the state is EMPTY: ex_vld=0, fch_rdy=1, ex_* data=0, skid_vld=0.
REQ-034 Reset overrides flush and any in-flight handshake, including a reset asserted while in FULL.

Structure
REQ-035 Shared package rv32i_dec_pkg holds:
- the format enum (3-bit)
- the RV32I opcode constants
- the decoded-bundle struct (pc, opcode, fmt, rd, rs1, rs2, funct3, funct7, imm, rd_we, ill)
REQ-036 OUT and SKID each store one bundle struct.
REQ-037 Field and immediate extraction reuses the existing rv32i_isa_dec as the only sub-module; the format mux and sequencing logic live in rv32i_dec_stage.

Verification
REQ-038 ADDI 0x00500093, pc 0x100, ex_rdy=1: next cycle ex_vld=1, ex_pc=0x100, fmt=I, rd=1, rs1=0, imm=5, rd_we=1, ill=0.
REQ-039 BEQ 0xFE000EE3: ex_fmt=B, ex_imm=0xFFFFFFFC, rs1=rs2=0, rd_we=0.
REQ-040 Back-pressure: with ex_rdy=0, send 2 instructions; fch_rdy=0 from the cycle after the 2nd transfer. Then raise ex_rdy: both instructions emerge in order on consecutive cycles and fch_rdy returns to 1.
REQ-041 Flush in FULL while fch_vld=1: next cycle ex_vld=0 and fch_rdy=1; the offered instruction never appears on ex_*.
REQ-042 0xFFFFFFFF: ILL_CHECK=1 gives ex_ill=1, fmt=NONE, rd_we=0, imm=0; ILL_CHECK=0 gives ex_ill=0.
REQ-043 rst asserted for 1 cycle while in FULL: next cycle ex_vld=0, fch_rdy=1; the first post-reset instruction decodes correctly.

Source files
------------

// File: rtl/rv32i_dec_pkg.sv
// Shared RV32I decode types: format codes, base opcodes, the decoded bundle
// and the decode-stage occupancy states.
package rv32i_dec_pkg;

  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_NONE = 3'd6
  } fmt_e;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;

  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  opcode;
    fmt_e        fmt;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        rd_we;
    logic        ill;
  } dec_bundle_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } stage_st_e;

endpackage

// File: rtl/rv32i_isa_dec.sv
// Raw RV32I field slicing and per-format immediate assembly; no format
// knowledge here, the stage selects which of these apply.
module rv32i_isa_dec (
  input  logic [31:0] ir,
  output logic [6:0]  opcode,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [31:0] imm_i,
  output logic [31:0] imm_s,
  output logic [31:0] imm_b,
  output logic [31:0] imm_u,
  output logic [31:0] imm_j
);

  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign funct3 = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign funct7 = ir[31:25];

  assign imm_i = {{20{ir[31]}}, ir[31:20]};
  assign imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b = {{20{ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};
  assign imm_u = {ir[31:12], 12'h000};
  assign imm_j = {{12{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};

endmodule

// File: rtl/rv32i_dec_stage.sv
// RV32I decode pipeline stage: combinational decode of the fetched word into
// a two-entry (OUT + SKID) registered buffer toward execute.
module rv32i_dec_stage
  import rv32i_dec_pkg::*;
#(
  parameter logic ILL_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fch_vld,
  output logic        fch_rdy,
  input  logic [31:0] fch_ir,
  input  logic [31:0] fch_pc,
  input  logic        flush,
  output logic        ex_vld,
  input  logic        ex_rdy,
  output logic [31:0] ex_pc,
  output logic [6:0]  ex_opcode,
  output logic [2:0]  ex_fmt,
  output logic [4:0]  ex_rd,
  output logic [4:0]  ex_rs1,
  output logic [4:0]  ex_rs2,
  output logic [2:0]  ex_funct3,
  output logic [6:0]  ex_funct7,
  output logic [31:0] ex_imm,
  output logic        ex_rd_we,
  output logic        ex_ill
);

  logic [6:0]  opc_s;
  logic [4:0]  rd_s;
  logic [4:0]  rs1_s;
  logic [4:0]  rs2_s;
  logic [2:0]  funct3_s;
  logic [6:0]  funct7_s;
  logic [31:0] imm_i_s;
  logic [31:0] imm_s_s;
  logic [31:0] imm_b_s;
  logic [31:0] imm_u_s;
  logic [31:0] imm_j_s;

  fmt_e        fmt_s;
  dec_bundle_t dec_s;

  stage_st_e   state_q, state_d;
  dec_bundle_t out_q, out_d;
  dec_bundle_t skid_q, skid_d;
  logic        ex_vld_q, ex_vld_d;
  logic        fch_rdy_q, fch_rdy_d;
  logic        fch_xfer_s;
  logic        ex_xfer_s;

  rv32i_isa_dec u_isa_dec (
    .ir     (fch_ir),
    .opcode (opc_s),
    .rd     (rd_s),
    .rs1    (rs1_s),
    .rs2    (rs2_s),
    .funct3 (funct3_s),
    .funct7 (funct7_s),
    .imm_i  (imm_i_s),
    .imm_s  (imm_s_s),
    .imm_b  (imm_b_s),
    .imm_u  (imm_u_s),
    .imm_j  (imm_j_s)
  );

  // Opcode to instruction format.
  always_comb begin
    fmt_s = FMT_NONE;
    case (opc_s)
      OPC_LUI, OPC_AUIPC:                          fmt_s = FMT_U;
      OPC_JAL:                                     fmt_s = FMT_J;
      OPC_JALR, OPC_LOAD, OPC_OP_IMM,
      OPC_MISC_MEM, OPC_SYSTEM:                    fmt_s = FMT_I;
      OPC_BRANCH:                                  fmt_s = FMT_B;
      OPC_STORE:                                   fmt_s = FMT_S;
      OPC_OP:                                      fmt_s = FMT_R;
      default:                                     fmt_s = FMT_NONE;
    endcase
  end

  // Bundle assembly; fields a format lacks (funct3 included) read as zero.
  always_comb begin
    dec_s        = '0;
    dec_s.pc     = fch_pc;
    dec_s.opcode = opc_s;
    dec_s.fmt    = fmt_s;
    case (fmt_s)
      FMT_R: begin
        dec_s.rd     = rd_s;
        dec_s.rs1    = rs1_s;
        dec_s.rs2    = rs2_s;
        dec_s.funct3 = funct3_s;
        dec_s.funct7 = funct7_s;
      end
      FMT_I: begin
        dec_s.rd     = rd_s;
        dec_s.rs1    = rs1_s;
        dec_s.funct3 = funct3_s;
        dec_s.imm    = imm_i_s;
      end
      FMT_S: begin
        dec_s.rs1    = rs1_s;
        dec_s.rs2    = rs2_s;
        dec_s.funct3 = funct3_s;
        dec_s.imm    = imm_s_s;
      end
      FMT_B: begin
        dec_s.rs1    = rs1_s;
        dec_s.rs2    = rs2_s;
        dec_s.funct3 = funct3_s;
        dec_s.imm    = imm_b_s;
      end
      FMT_U: begin
        dec_s.rd  = rd_s;
        dec_s.imm = imm_u_s;
      end
      FMT_J: begin
        dec_s.rd  = rd_s;
        dec_s.imm = imm_j_s;
      end
      default: begin
        dec_s.fmt = FMT_NONE;
      end
    endcase
    dec_s.ill = ILL_CHECK & ((fmt_s == FMT_NONE) | (fch_ir[1:0] != 2'b11));
    if (((fmt_s == FMT_R) || (fmt_s == FMT_I) || (fmt_s == FMT_U) || (fmt_s == FMT_J))
        && (dec_s.rd != 5'd0) && !dec_s.ill) begin
      dec_s.rd_we = 1'b1;
    end else begin
      dec_s.rd_we = 1'b0;
    end
  end

  assign fch_xfer_s = fch_vld & fch_rdy_q;
  assign ex_xfer_s  = ex_vld_q & ex_rdy;

  // Occupancy sequencing; flush beats every transfer.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (fch_xfer_s) begin
            out_d   = dec_s;
            state_d = ST_ONE;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (fch_xfer_s && ex_xfer_s) begin
            out_d   = dec_s;
            state_d = ST_ONE;
          end else if (fch_xfer_s) begin
            skid_d  = dec_s;
            state_d = ST_FULL;
          end else if (ex_xfer_s) begin
            state_d = ST_EMPTY;
          end else begin
            state_d = ST_ONE;
          end
        end
        ST_FULL: begin
          if (ex_xfer_s) begin
            out_d   = skid_q;
            state_d = ST_ONE;
          end else begin
            state_d = ST_FULL;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
    ex_vld_d  = (state_d != ST_EMPTY);
    fch_rdy_d = (state_d != ST_FULL);
  end

  // Stage registers; handshake flags are registered alongside the data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_EMPTY;
      out_q     <= '0;
      skid_q    <= '0;
      ex_vld_q  <= 1'b0;
      fch_rdy_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      out_q     <= out_d;
      skid_q    <= skid_d;
      ex_vld_q  <= ex_vld_d;
      fch_rdy_q <= fch_rdy_d;
    end
  end

  assign fch_rdy   = fch_rdy_q;
  assign ex_vld    = ex_vld_q;
  assign ex_pc     = out_q.pc;
  assign ex_opcode = out_q.opcode;
  assign ex_fmt    = out_q.fmt;
  assign ex_rd     = out_q.rd;
  assign ex_rs1    = out_q.rs1;
  assign ex_rs2    = out_q.rs2;
  assign ex_funct3 = out_q.funct3;
  assign ex_funct7 = out_q.funct7;
  assign ex_imm    = out_q.imm;
  assign ex_rd_we  = out_q.rd_we;
  assign ex_ill    = out_q.ill;

endmodule

// File: tb/tb_rv32i_dec_stage.sv
// Scoreboard bench for rv32i_dec_stage: directed RV32I words with
// hand-computed decodes, back-pressure, flush and reset-in-FULL scenarios.
module tb_rv32i_dec_stage;
  import rv32i_dec_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, fch_vld, flush, ex_rdy;
  logic [31:0] fch_ir, fch_pc;

  logic        fch_rdy_a, ex_vld_a, ex_rd_we_a, ex_ill_a;
  logic [31:0] ex_pc_a, ex_imm_a;
  logic [6:0]  ex_opcode_a, ex_funct7_a;
  logic [2:0]  ex_fmt_a, ex_funct3_a;
  logic [4:0]  ex_rd_a, ex_rs1_a, ex_rs2_a;

  logic        fch_rdy_b, ex_vld_b, ex_rd_we_b, ex_ill_b;
  logic [31:0] ex_pc_b, ex_imm_b;
  logic [6:0]  ex_opcode_b, ex_funct7_b;
  logic [2:0]  ex_fmt_b, ex_funct3_b;
  logic [4:0]  ex_rd_b, ex_rs1_b, ex_rs2_b;

  rv32i_dec_stage #(.ILL_CHECK(1'b1)) dut_a (
    .clk(clk), .rst(rst), .fch_vld(fch_vld), .fch_rdy(fch_rdy_a),
    .fch_ir(fch_ir), .fch_pc(fch_pc), .flush(flush),
    .ex_vld(ex_vld_a), .ex_rdy(ex_rdy), .ex_pc(ex_pc_a), .ex_opcode(ex_opcode_a),
    .ex_fmt(ex_fmt_a), .ex_rd(ex_rd_a), .ex_rs1(ex_rs1_a), .ex_rs2(ex_rs2_a),
    .ex_funct3(ex_funct3_a), .ex_funct7(ex_funct7_a), .ex_imm(ex_imm_a),
    .ex_rd_we(ex_rd_we_a), .ex_ill(ex_ill_a)
  );

  rv32i_dec_stage #(.ILL_CHECK(1'b0)) dut_b (
    .clk(clk), .rst(rst), .fch_vld(fch_vld), .fch_rdy(fch_rdy_b),
    .fch_ir(fch_ir), .fch_pc(fch_pc), .flush(flush),
    .ex_vld(ex_vld_b), .ex_rdy(ex_rdy), .ex_pc(ex_pc_b), .ex_opcode(ex_opcode_b),
    .ex_fmt(ex_fmt_b), .ex_rd(ex_rd_b), .ex_rs1(ex_rs1_b), .ex_rs2(ex_rs2_b),
    .ex_funct3(ex_funct3_b), .ex_funct7(ex_funct7_b), .ex_imm(ex_imm_b),
    .ex_rd_we(ex_rd_we_b), .ex_ill(ex_ill_b)
  );

  typedef struct {
    logic [31:0] ir;
    dec_bundle_t exp;
  } vec_t;

  vec_t        vecs[$];
  dec_bundle_t exp_q[$];
  dec_bundle_t held;
  dec_bundle_t mon_e;
  logic        held_vld = 1'b0;
  int          checks = 0;
  int          errors = 0;
  int          pops = 0;

  function automatic dec_bundle_t bun_a();
    dec_bundle_t b;
    b.pc = ex_pc_a; b.opcode = ex_opcode_a; b.fmt = fmt_e'(ex_fmt_a);
    b.rd = ex_rd_a; b.rs1 = ex_rs1_a; b.rs2 = ex_rs2_a;
    b.funct3 = ex_funct3_a; b.funct7 = ex_funct7_a; b.imm = ex_imm_a;
    b.rd_we = ex_rd_we_a; b.ill = ex_ill_a;
    return b;
  endfunction

  function automatic dec_bundle_t bun_b();
    dec_bundle_t b;
    b.pc = ex_pc_b; b.opcode = ex_opcode_b; b.fmt = fmt_e'(ex_fmt_b);
    b.rd = ex_rd_b; b.rs1 = ex_rs1_b; b.rs2 = ex_rs2_b;
    b.funct3 = ex_funct3_b; b.funct7 = ex_funct7_b; b.imm = ex_imm_b;
    b.rd_we = ex_rd_we_b; b.ill = ex_ill_b;
    return b;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic chk_b(input string name, input dec_bundle_t act, input dec_bundle_t req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual pc=%h op=%h fmt=%0d rd=%0d rs1=%0d rs2=%0d f3=%0d f7=%h imm=%h we=%b ill=%b required pc=%h op=%h fmt=%0d rd=%0d rs1=%0d rs2=%0d f3=%0d f7=%h imm=%h we=%b ill=%b",
               name, act.pc, act.opcode, act.fmt, act.rd, act.rs1, act.rs2, act.funct3,
               act.funct7, act.imm, act.rd_we, act.ill, req.pc, req.opcode, req.fmt,
               req.rd, req.rs1, req.rs2, req.funct3, req.funct7, req.imm, req.rd_we, req.ill);
    end
  endtask

  task automatic add_vec(input logic [31:0] ir, input logic [31:0] pc, input fmt_e fmt,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm,
                         input logic we, input logic ill);
    vec_t v;
    v.ir = ir;
    v.exp.pc = pc; v.exp.opcode = ir[6:0]; v.exp.fmt = fmt;
    v.exp.rd = rd; v.exp.rs1 = rs1; v.exp.rs2 = rs2;
    v.exp.funct3 = f3; v.exp.funct7 = f7; v.exp.imm = imm;
    v.exp.rd_we = we; v.exp.ill = ill;
    vecs.push_back(v);
  endtask

  // Offer one instruction; expectation is queued at the edge that accepts it.
  task automatic send(input int i, input logic [31:0] pc);
    bit          done = 1'b0;
    dec_bundle_t e;
    e = vecs[i].exp;
    e.pc = pc;
    fch_vld = 1'b1; fch_ir = vecs[i].ir; fch_pc = pc;
    for (int c = 0; c < 20 && !done; c++) begin
      if (fch_rdy_a) begin
        exp_q.push_back(e);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    fch_vld = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL send_timeout actual=no_accept required=accept vec=%0d", i);
    end
  endtask

  // Monitor: stability under back-pressure and in-order scoreboard pops.
  always @(negedge clk) begin
    if (!rst && !flush) begin
      if (ex_vld_a && !ex_rdy) begin
        if (held_vld) chk_b("hold_stable", bun_a(), held);
        held     = bun_a();
        held_vld = 1'b1;
      end else begin
        held_vld = 1'b0;
      end
      if (ex_vld_a && ex_rdy) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_out actual pc=%h required=none", ex_pc_a);
        end else begin
          mon_e = exp_q.pop_front();
          chk_b("bundle_ill1", bun_a(), mon_e);
          mon_e.ill = 1'b0;
          chk_b("bundle_ill0", bun_b(), mon_e);
          chk("vld_ill0", {31'd0, ex_vld_b}, 32'd1);
          pops++;
        end
      end
    end else begin
      held_vld = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int p0;
    rst = 1'b1; fch_vld = 1'b0; flush = 1'b0; ex_rdy = 1'b0;
    fch_ir = 32'd0; fch_pc = 32'd0;

    add_vec(32'h00500093, 32'h100, FMT_I,    5'd1,  5'd0, 5'd0, 3'd0, 7'h00, 32'h00000005, 1'b1, 1'b0);
    add_vec(32'hFE000EE3, 32'h104, FMT_B,    5'd0,  5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFFFFC, 1'b0, 1'b0);
    add_vec(32'h123452B7, 32'h108, FMT_U,    5'd5,  5'd0, 5'd0, 3'd0, 7'h00, 32'h12345000, 1'b1, 1'b0);
    add_vec(32'h0020A423, 32'h10C, FMT_S,    5'd0,  5'd1, 5'd2, 3'd2, 7'h00, 32'h00000008, 1'b0, 1'b0);
    add_vec(32'h402081B3, 32'h110, FMT_R,    5'd3,  5'd1, 5'd2, 3'd0, 7'h20, 32'h00000000, 1'b1, 1'b0);
    add_vec(32'hFFDFF0EF, 32'h114, FMT_J,    5'd1,  5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFFFFC, 1'b1, 1'b0);
    add_vec(32'h00000013, 32'h118, FMT_I,    5'd0,  5'd0, 5'd0, 3'd0, 7'h00, 32'h00000000, 1'b0, 1'b0);
    add_vec(32'hFFFFFFFF, 32'h11C, FMT_NONE, 5'd0,  5'd0, 5'd0, 3'd0, 7'h00, 32'h00000000, 1'b0, 1'b1);
    add_vec(32'hFFF12503, 32'h120, FMT_I,    5'd10, 5'd2, 5'd0, 3'd2, 7'h00, 32'hFFFFFFFF, 1'b1, 1'b0);
    add_vec(32'h00000073, 32'h124, FMT_I,    5'd0,  5'd0, 5'd0, 3'd0, 7'h00, 32'h00000000, 1'b0, 1'b0);
    add_vec(32'hFFFFF217, 32'h128, FMT_U,    5'd4,  5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFF000, 1'b1, 1'b0);
    add_vec(32'h00000000, 32'h12C, FMT_NONE, 5'd0,  5'd0, 5'd0, 3'd0, 7'h00, 32'h00000000, 1'b0, 1'b1);

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_ex_vld", {31'd0, ex_vld_a}, 32'd0);
    chk("rst_fch_rdy", {31'd0, fch_rdy_a}, 32'd1);
    chk_b("rst_bundle", bun_a(), '0);

    // Streaming with execute always ready; first bundle visible one cycle later.
    ex_rdy = 1'b1;
    send(0, vecs[0].exp.pc);
    chk("latency_ex_vld", {31'd0, ex_vld_a}, 32'd1);
    for (int i = 1; i < vecs.size(); i++) send(i, vecs[i].exp.pc);
    repeat (3) @(posedge clk);
    #1 chk("stream_drained", exp_q.size(), 32'd0);

    // Back-pressure: two accepted, then stall, then drain in order.
    ex_rdy = 1'b0;
    send(3, 32'h200);
    chk("bp_rdy_after_1", {31'd0, fch_rdy_a}, 32'd1);
    send(4, 32'h204);
    chk("bp_rdy_after_2", {31'd0, fch_rdy_a}, 32'd0);
    repeat (2) @(posedge clk);
    #1 chk("bp_rdy_hold", {31'd0, fch_rdy_a}, 32'd0);
    p0 = pops;
    ex_rdy = 1'b1;
    @(posedge clk); #1;
    chk("bp_rdy_back", {31'd0, fch_rdy_a}, 32'd1);
    @(posedge clk); #1;
    chk("bp_two_out", pops - p0, 32'd2);
    chk("bp_empty", {31'd0, ex_vld_a}, 32'd0);

    // Flush while FULL with an instruction on offer.
    ex_rdy = 1'b0;
    send(0, 32'h300);
    send(1, 32'h304);
    fch_vld = 1'b1; fch_ir = vecs[2].ir; fch_pc = 32'hDEAD0000;
    flush = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    flush = 1'b0; fch_vld = 1'b0;
    chk("flush_ex_vld", {31'd0, ex_vld_a}, 32'd0);
    chk("flush_fch_rdy", {31'd0, fch_rdy_a}, 32'd1);
    ex_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1 send(8, 32'h308);
    repeat (2) @(posedge clk);

    // Reset pulse while FULL.
    #1 ex_rdy = 1'b0;
    send(5, 32'h400);
    send(6, 32'h404);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rstfull_ex_vld", {31'd0, ex_vld_a}, 32'd0);
    chk("rstfull_fch_rdy", {31'd0, fch_rdy_a}, 32'd1);
    chk_b("rstfull_bundle", bun_a(), '0);
    ex_rdy = 1'b1;
    send(0, 32'h100);
    chk("post_rst_vld", {31'd0, ex_vld_a}, 32'd1);
    repeat (3) @(posedge clk);
    #1 chk("final_drained", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
